// File: rtl/lcmv_filter_apply_pkg.sv
// Shared hyperspectral types: filter-apply sequencer states and ALU/matrix handshake helpers.
package lcmv_filter_apply_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ_COL,
        ST_WAIT_COL,
        ST_ISSUE,
        ST_WAIT_DOT,
        ST_EMIT,
        ST_DONE
    } lcmv_state_t;

    typedef enum logic {
        ALU_MODE_PASS = 1'b0,
        ALU_MODE_DOT  = 1'b1
    } alu_mode_t;

    typedef struct packed {
        logic req;
        logic ack;
    } mat_hs_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcmv_filter_apply_if.sv
// Result stream of the filter-apply block: one word per output channel, last flags the pixel end.
interface lcmv_filter_apply_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/lcmv_filter_apply_pixel_buffer.sv
// Pixel vector buffer: one word written per cycle by slot index, whole vector read in parallel.
module pixel_vector_buffer
    import lcmv_filter_apply_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 169
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [safe_clog2(DEPTH)-1:0]   wr_idx,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [DEPTH*WIDTH-1:0]         vec
);
    localparam int IDX_W = safe_clog2(DEPTH);

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == IDX_W'(g)) begin
                vec[g*WIDTH +: WIDTH] <= wr_data;
            end
        end
    end
endmodule

// File: rtl/lcmv_filter_apply.sv
// LCMV filter apply: for each pixel, dot the spectral vector against every W column and stream results.
// state      | meaning
// IDLE       | waiting for start (W complete)
// LOAD       | shifting one pixel's channels into the pixel buffer
// REQ_COL    | one-cycle read request for W column j
// WAIT_COL   | waiting for the column to return from memory
// ISSUE      | presenting pixel/column to the vector ALU once it is ready
// WAIT_DOT   | waiting for the dot-product result
// EMIT       | holding the result word until the consumer accepts it
// DONE       | one-cycle finished pulse
module lcmv_filter_apply
    import lcmv_filter_apply_pkg::*;
#(
    parameter int WIDTH               = 32,
    parameter int NUM_PIXELS          = 4096,
    parameter int NUM_CHANNELS        = 169,
    parameter int NUM_OUTPUT_CHANNELS = 3,
    parameter int MEMORY_LATENCY      = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       finished,
    output logic                                       ds_next_data,
    input  logic [WIDTH-1:0]                           ds_out,
    input  logic                                       ds_valid,
    output logic [safe_clog2(NUM_OUTPUT_CHANNELS)-1:0] w_col_addr,
    output logic                                       w_col_addr_ready,
    input  logic                                       w_col_valid,
    input  logic [NUM_CHANNELS*WIDTH-1:0]              w_col_out,
    output logic [NUM_CHANNELS*WIDTH-1:0]              dot_product_a,
    output logic [NUM_CHANNELS*WIDTH-1:0]              dot_product_b,
    output logic [WIDTH-1:0]                           dot_product_c,
    output logic [NUM_CHANNELS-1:0]                    dot_product_enable,
    output logic                                       dot_product_mode,
    input  logic                                       alu_ready,
    input  logic                                       dot_product_valid,
    input  logic [WIDTH-1:0]                           dot_product_out,
    lcmv_filter_apply_if.master                        res
);
    localparam int CH_W     = safe_clog2(NUM_CHANNELS);
    localparam int COL_W    = safe_clog2(NUM_OUTPUT_CHANNELS);
    localparam int PIX_W    = $clog2(NUM_PIXELS + 1);
    localparam int LAT_W    = safe_clog2(MEMORY_LATENCY + 1);
    localparam int LAT_LOAD = (MEMORY_LATENCY > 0) ? MEMORY_LATENCY - 1 : 0;

    localparam logic [CH_W-1:0]  K_LAST   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [COL_W-1:0] J_LAST   = COL_W'(NUM_OUTPUT_CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

    lcmv_state_t             state_q, state_d;
    logic [CH_W-1:0]         k_q, k_d;
    logic [COL_W-1:0]        j_q, j_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [WIDTH-1:0]        out_data_q;
    logic [NUM_CHANNELS*WIDTH-1:0] pix_vec;
    logic [NUM_CHANNELS*WIDTH-1:0] col_buf;
    logic                    pix_wr, col_ld, out_ld, issue;

    pixel_vector_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (NUM_CHANNELS)
    ) u_pix_buf (
        .clk     (clk),
        .wr_en   (pix_wr),
        .wr_idx  (k_q),
        .wr_data (ds_out),
        .vec     (pix_vec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            pix_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            pix_q   <= pix_d;
            lat_q   <= lat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q <= '0;
        end else if (out_ld) begin
            out_data_q <= dot_product_out;
        end
    end

    always_ff @(posedge clk) begin
        if (col_ld) begin
            col_buf <= w_col_out;
        end
    end

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        j_d              = j_q;
        pix_d            = pix_q;
        lat_d            = lat_q;
        pix_wr           = 1'b0;
        col_ld           = 1'b0;
        out_ld           = 1'b0;
        issue            = 1'b0;
        ds_next_data     = 1'b0;
        w_col_addr_ready = 1'b0;
        finished         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = '0;
                    j_d     = '0;
                    pix_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ds_next_data = 1'b1;
                if (ds_valid) begin
                    pix_wr = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        j_d     = '0;
                        state_d = ST_REQ_COL;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_REQ_COL: begin
                w_col_addr_ready = 1'b1;
                lat_d            = LAT_W'(LAT_LOAD);
                state_d          = ST_WAIT_COL;
            end
            ST_WAIT_COL: begin
                // Data cannot be back before the memory latency expires; earlier strobes are stale.
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else if (w_col_valid) begin
                    col_ld  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (alu_ready) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT_DOT;
                end
            end
            ST_WAIT_DOT: begin
                if (dot_product_valid) begin
                    out_ld  = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (res.out_ready) begin
                    if (j_q < J_LAST) begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_REQ_COL;
                    end else if (pix_q < PIX_LAST) begin
                        pix_d   = pix_q + 1'b1;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = ST_LOAD;
                    end else begin
                        pix_d   = '0;
                        j_d     = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                finished = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_col_addr         = (state_q == ST_REQ_COL) ? j_q : '0;
    assign dot_product_a      = issue ? pix_vec : '0;
    assign dot_product_b      = issue ? col_buf : '0;
    assign dot_product_c      = '0;
    assign dot_product_enable = {NUM_CHANNELS{issue}};
    assign dot_product_mode   = (state_q == ST_ISSUE || state_q == ST_WAIT_DOT) ? ALU_MODE_DOT : ALU_MODE_PASS;

    assign res.out_data  = out_data_q;
    assign res.out_valid = (state_q == ST_EMIT);
    assign res.out_last  = (j_q == J_LAST);
endmodule

// File: tb/tb_lcmv_filter_apply.sv
// Bench for lcmv_filter_apply: behavioural W memory and vector ALU, scoreboard on the result stream.
module tb_lcmv_filter_apply;
    localparam int WIDTH = 32;
    localparam int NP    = 2;
    localparam int NC    = 4;
    localparam int NOC   = 2;
    localparam int ML    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic finished;
    logic ds_next_data;
    logic [WIDTH-1:0] ds_out = '0;
    logic ds_valid = 1'b0;
    logic [0:0] w_col_addr;
    logic w_col_addr_ready;
    logic w_col_valid = 1'b0;
    logic [NC*WIDTH-1:0] w_col_out = '0;
    logic [NC*WIDTH-1:0] dot_product_a, dot_product_b;
    logic [WIDTH-1:0] dot_product_c;
    logic [NC-1:0] dot_product_enable;
    logic dot_product_mode;
    logic alu_ready = 1'b1;
    logic dot_product_valid = 1'b0;
    logic [WIDTH-1:0] dot_product_out = '0;
    logic out_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int issues = 0;
    int words_taken = 0;
    bit gaps = 0;
    bit noise = 0;
    bit fin_pend = 0;

    int w_tab[NOC][NC] = '{'{1, 1, 1, 1}, '{1, 0, 0, 0}};
    logic [WIDTH-1:0] src_q[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lcmv_filter_apply_if #(.WIDTH(WIDTH)) res_if ();
    assign res_if.out_ready = out_ready;

    lcmv_filter_apply #(
        .WIDTH               (WIDTH),
        .NUM_PIXELS          (NP),
        .NUM_CHANNELS        (NC),
        .NUM_OUTPUT_CHANNELS (NOC),
        .MEMORY_LATENCY      (ML)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .finished           (finished),
        .ds_next_data       (ds_next_data),
        .ds_out             (ds_out),
        .ds_valid           (ds_valid),
        .w_col_addr         (w_col_addr),
        .w_col_addr_ready   (w_col_addr_ready),
        .w_col_valid        (w_col_valid),
        .w_col_out          (w_col_out),
        .dot_product_a      (dot_product_a),
        .dot_product_b      (dot_product_b),
        .dot_product_c      (dot_product_c),
        .dot_product_enable (dot_product_enable),
        .dot_product_mode   (dot_product_mode),
        .alu_ready          (alu_ready),
        .dot_product_valid  (dot_product_valid),
        .dot_product_out    (dot_product_out),
        .res                (res_if)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_pixel(input int p0, input int p1, input int p2, input int p3, input bit last_px);
        int px[NC];
        exp_t e;
        px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
        for (int i = 0; i < NC; i++) src_q.push_back(WIDTH'(px[i]));
        for (int c = 0; c < NOC; c++) begin
            int s = 0;
            for (int i = 0; i < NC; i++) s += px[i] * w_tab[c][i];
            e.data = WIDTH'(s);
            e.last = (c == NOC - 1);
            e.fin  = last_px && (c == NOC - 1);
            exp_q.push_back(e);
        end
    endtask

    // Pixel source: a word offered while ds_next_data is high is consumed at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            ds_valid = 1'b0;
        end else if (ds_next_data && src_q.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
            ds_valid = 1'b1;
            ds_out   = src_q.pop_front();
            words_taken++;
        end else begin
            ds_valid = noise && !ds_next_data && ($urandom_range(0, 2) == 0);
            ds_out   = 32'hdeadbeef;
        end
    end

    int wcnt = 0;
    logic [0:0] waddr = '0;
    always @(negedge clk) begin
        w_col_valid = 1'b0;
        if (!rst) begin
            wcnt = 0;
        end else begin
            if (wcnt != 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    w_col_valid = 1'b1;
                    for (int i = 0; i < NC; i++) w_col_out[i*WIDTH +: WIDTH] = WIDTH'(w_tab[waddr][i]);
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                w_col_valid = 1'b1;
                w_col_out   = '1;
            end
            if (w_col_addr_ready) begin
                wcnt  = ML;
                waddr = w_col_addr;
            end
        end
    end

    int acnt = 0;
    logic [WIDTH-1:0] ares = '0;
    always @(negedge clk) begin
        dot_product_valid = 1'b0;
        if (!rst) begin
            acnt = 0;
        end else begin
            if (acnt != 0) begin
                acnt--;
                if (acnt == 0) begin
                    dot_product_valid = 1'b1;
                    dot_product_out   = ares;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                dot_product_valid = 1'b1;
                dot_product_out   = 32'hbad0bad0;
            end
            if (dot_product_enable != '0) begin
                issues++;
                check_eq("issue_en", dot_product_enable, {NC{1'b1}});
                check_eq("issue_ready", alu_ready, 1);
                check_eq("issue_mode", dot_product_mode, 1);
                check_eq("issue_c", dot_product_c, 0);
                ares = '0;
                for (int i = 0; i < NC; i++)
                    ares += dot_product_a[i*WIDTH +: WIDTH] * dot_product_b[i*WIDTH +: WIDTH];
                acnt = 3;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check_eq("finished", finished, fin_pend);
        fin_pend = 0;
        if (rst && res_if.out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", res_if.out_data, e.data);
                check_eq("out_last", res_if.out_last, e.last);
                fin_pend = e.fin;
            end
        end
    end

    task automatic kick();
        bit seen = 0;
        @(posedge clk); #1 start = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ds_next_data;
        end
        check_eq("kick_load", seen, 1);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = finished;
        end
        check_eq("done_timeout", seen, 1);
        repeat (2) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_dsnext"}, ds_next_data, 0);
        check_eq({tag, "_valid"}, res_if.out_valid, 0);
        check_eq({tag, "_fin"}, finished, 0);
        check_eq({tag, "_en"}, dot_product_enable, 0);
        check_eq({tag, "_mode"}, dot_product_mode, 0);
        check_eq({tag, "_wreq"}, w_col_addr_ready, 0);
        check_eq({tag, "_data"}, res_if.out_data, 0);
    endtask

    initial begin
        int i0, w0, chg, dsn;
        logic [WIDTH-1:0] d0;
        bit seen;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Reference image
        i0 = issues;
        push_pixel(1, 2, 3, 4, 0);
        push_pixel(0, 0, 0, 1, 1);
        kick();
        wait_done();
        check_eq("issues_img1", issues - i0, NP * NOC);

        // Valid gaps and stray strobes give the same image, exactly NC words per pixel
        gaps = 1; noise = 1;
        w0 = words_taken;
        push_pixel(1, 2, 3, 4, 0);
        push_pixel(0, 0, 0, 1, 1);
        kick();
        wait_done();
        check_eq("gap_words", words_taken - w0, NP * NC);
        gaps = 0; noise = 0;

        // Consumer backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        push_pixel($urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 200), 7, 0);
        push_pixel(5, $urandom_range(0, 200), 9, $urandom_range(0, 200), 1);
        kick();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = res_if.out_valid;
        end
        check_eq("bp_valid", seen, 1);
        d0 = res_if.out_data; i0 = issues; chg = 0; dsn = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_if.out_data !== d0 || res_if.out_valid !== 1'b1) chg++;
            if (ds_next_data) dsn++;
        end
        check_eq("bp_stable", chg, 0);
        check_eq("bp_dsnext", dsn, 0);
        check_eq("bp_issue", issues - i0, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done();

        // ALU not ready
        @(posedge clk); #1 alu_ready = 1'b0;
        i0 = issues;
        push_pixel(3, 1, 4, 1, 0);
        push_pixel(5, 9, 2, 6, 1);
        kick();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = dot_product_mode;
        end
        check_eq("alu_reach_issue", seen, 1);
        repeat (10) @(negedge clk);
        check_eq("alu_hold", issues - i0, 0);
        @(posedge clk); #1 alu_ready = 1'b1;
        wait_done();
        check_eq("issues_alu", issues - i0, NP * NOC);

        // Reset during WAIT_DOT, then a clean rerun
        push_pixel(2, 2, 2, 2, 0);
        push_pixel(1, 1, 1, 1, 1);
        kick();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (dot_product_enable != '0);
        end
        check_eq("rst_reach_issue", seen, 1);
        @(posedge clk); #1 rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b1;
        i0 = issues;
        push_pixel(1, 2, 3, 4, 0);
        push_pixel(0, 0, 0, 1, 1);
        kick();
        wait_done();
        check_eq("issues_rerun", issues - i0, NP * NOC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcmv_filter_apply.md
LCMV_FILTER_APPLY -- requirements
Module: lcmv_filter_apply

Interface
- REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  - WIDTH, 32, scalar width.
  - NUM_PIXELS, 4096, pixels per image.
  - NUM_CHANNELS, 169, input spectral channels.
  - NUM_OUTPUT_CHANNELS, 3, output channels.
  - MEMORY_LATENCY, 2, W column read latency.
- REQ-002 clk  input  1  sole clock; all logic on its rising edge.
- REQ-003 rst  input  1  asynchronous, active-low reset.
- REQ-004 start  input  1  level; high once W is complete (driven by weighting finished).
- REQ-005 finished  output  1  one-cycle pulse after the last output word of the image is accepted.
- REQ-006 ds_next_data  output  1; ds_out  input  WIDTH; ds_valid  input  1: pixel stream, channel-major, NUM_CHANNELS words per pixel.
- REQ-007 w_col_addr  output  clog2(NUM_OUTPUT_CHANNELS); w_col_addr_ready  output  1 (request strobe); w_col_valid  input  1; w_col_out  input  NUM_CHANNELS*WIDTH: W column read port.
- REQ-008 dot_product_a, dot_product_b  output  NUM_CHANNELS*WIDTH; dot_product_c  output  WIDTH; dot_product_enable  output  NUM_CHANNELS; dot_product_mode  output  1; alu_ready  input  1; dot_product_valid  input  1; dot_product_out  input  WIDTH: FP vector ALU port.
- REQ-009 out_data  output  WIDTH; out_valid  output  1; out_ready  input  1; out_last  output  1: result stream.

Function
- REQ-010 The FSM SHALL have states IDLE, LOAD, REQ_COL, WAIT_COL, ISSUE, WAIT_DOT, EMIT, DONE.
- REQ-011 IDLE SHALL go to LOAD when start=1.
- REQ-012 LOAD SHALL hold ds_next_data=1 and write ds_out into pixel buffer slot k on each cycle with ds_valid=1, k=0..NUM_CHANNELS-1; after slot NUM_CHANNELS-1 it SHALL go to REQ_COL with j=0.
- REQ-013 ds_next_data SHALL be 0 in every state other than LOAD.
- REQ-014 REQ_COL SHALL drive w_col_addr=j with w_col_addr_ready=1 for exactly one cycle, then go to WAIT_COL.
- REQ-015 WAIT_COL SHALL latch w_col_out into the column buffer on w_col_valid, which arrives MEMORY_LATENCY cycles after the request.
- REQ-016 ISSUE SHALL wait for alu_ready=1, then present a=pixel buffer, b=column buffer, c=0, enable=all-ones for one cycle and go to WAIT_DOT.
- REQ-017 dot_product_enable SHALL be 0 outside the issue cycle.
- REQ-018 dot_product_mode SHALL be 1 from ISSUE through WAIT_DOT and 0 otherwise.
- REQ-019 WAIT_DOT SHALL capture dot_product_out into the out_data register on dot_product_valid, then go to EMIT.
- REQ-020 EMIT SHALL hold out_valid=1 with out_data stable until out_ready=1.
- REQ-021 out_last SHALL be 1 exactly when j=NUM_OUTPUT_CHANNELS-1.
- REQ-022 On the EMIT handshake the FSM SHALL go as follows:
  - j<NUM_OUTPUT_CHANNELS-1: j+1, to REQ_COL.
  - else if pixel count<NUM_PIXELS-1: to LOAD.
  - else: to DONE.
- REQ-023 DONE SHALL pulse finished for one cycle and return to IDLE; a new start re-runs the image.
- REQ-024 Pixel counter width SHALL be clog2(NUM_PIXELS+1); channel and output counters SHALL not wrap mid-pixel.
- REQ-025 start deasserting mid-image SHALL have no effect; only reset aborts.
- REQ-026 ds_valid=0 in LOAD SHALL stall without advancing k.
- REQ-027 The block SHALL ignore w_col_valid outside WAIT_COL and dot_product_valid outside WAIT_DOT.

Reset
- REQ-028 With rst=0 the FSM SHALL be IDLE, all counters 0, and all outputs 0, including ds_next_data, out_valid, finished, enables and mode.
- REQ-029 Reset asserted mid-operation SHALL abort immediately; buffers need not clear.

Structure
- REQ-030 The FSM state enum SHALL live in the shared hyperspectral package with the ALU/matrix handshake typedefs.
- REQ-031 The pixel buffer SHALL be a sub-module, pixel_vector_buffer (serial write, parallel read).

Verification
- REQ-032 Run the bench with NUM_CHANNELS=4, NUM_OUTPUT_CHANNELS=2, NUM_PIXELS=2, using behavioural W and ALU models.
- REQ-033 Pixels {1,2,3,4},{0,0,0,1} with W cols {1,1,1,1},{1,0,0,0} -> outputs 10,1,1,0; out_last on words 2 and 4; finished one cycle after word 4.
- REQ-034 Gaps in ds_valid during LOAD -> identical results; no extra slots written.
- REQ-035 out_ready held low 20 cycles in EMIT -> out_data stable, ds_next_data=0, no ALU issue.
- REQ-036 alu_ready low 10 cycles -> no enable until alu_ready=1; exactly one issue per output.
- REQ-037 rst=0 during WAIT_DOT -> all outputs 0 next edge; a fresh start produces the correct image.
